bpb_update_sched: RTL

//  Schedules all writes into the branch-prediction buffer (BPB) tables for a 2-way superscalar core.

---
 rtl/bpb_pkg.sv | 34 +++
 rtl/bpb_upd_fifo.sv | 66 ++++++
 rtl/bpb_update_sched.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bpb_pkg.sv
// Shared types and sizing helpers for the BPB update scheduler.
//   bpb_upd_t         : one queued table update (tag, direction, target, mistake)
//   bpb_sched_state_e : scheduler phase, clear sweep (INIT) or normal issue (RUN)
//   bpb_idx_w()       : entry index width for a given table size
package bpb_pkg;

    localparam int BPB_ENTRIES = 8;
    localparam int BPB_TAG_W   = 16;

    typedef struct packed {
        logic [BPB_TAG_W-1:0] tag;
        logic                 taken;
        logic [31:0]          target;
        logic                 mistake;
    } bpb_upd_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bpb_sched_state_e;

    // Index width of a table with the given number of entries (at least 1 bit).
    function automatic int bpb_idx_w(input int entries);
        int w;
        w = $clog2(entries);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/bpb_upd_fifo.sv
// In-order update queue with two write lanes and one read lane.
//   clk, reset       : clock, synchronous active-high reset (empties the queue)
//   push_a, data_a   : first (older) write lane
//   push_b, data_b   : second (younger) write lane; only used together with push_a
//   pop              : remove the head entry
//   head             : oldest entry (valid when count != 0)
//   count            : number of occupied slots
// The caller guarantees there is room for every push and that pop only
// happens when count != 0.
module bpb_upd_fifo #(
    parameter int DW     = 50,
    parameter int QDEPTH = 4,
    parameter int PW     = (QDEPTH > 2) ? $clog2(QDEPTH) : 1,
    parameter int CW     = $clog2(QDEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_a,
    input  logic [DW-1:0] data_a,
    input  logic          push_b,
    input  logic [DW-1:0] data_b,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count
);

    logic [DW-1:0] r_mem [QDEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_nadd;
    logic [CW-1:0] w_npop;

    // Number of entries added and removed this cycle.
    always_comb begin
        w_nadd = CW'(push_a) + CW'(push_b);
        w_npop = CW'(pop);
    end

    // Entry storage; lane b lands in the slot right after lane a.
    always_ff @(posedge clk) begin
        if (push_a) begin
            r_mem[r_wptr] <= data_a;
        end
        if (push_b) begin
            r_mem[r_wptr + PW'(1)] <= data_b;
        end
    end

    // Pointers and occupancy; pointers wrap because QDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_nadd);
            r_rptr  <= r_rptr + PW'(w_npop);
            r_count <= r_count + w_nadd - w_npop;
        end
    end

    assign head  = r_mem[r_rptr];
    assign count = r_count;

endmodule

// File: rtl/bpb_update_sched.sv
// BPB write scheduler for a 2-way core. After reset it sweeps every BPB entry
// with a clear write, then issues queued branch resolutions, one per cycle.
//   clk, reset          : clock, synchronous active-high reset
//   stall               : write port frozen (no pop, no sweep advance)
//   res0_*/res1_*       : older/younger branch resolutions
//   res_ready           : queue can accept two entries this cycle
//   upd_*               : BPB write port (strobe, clear flag, index, payload)
//   init_done           : clear sweep finished
//   drop_cnt            : saturating count of dropped resolutions
module bpb_update_sched
    import bpb_pkg::*;
#(
    parameter int ENTRIES   = BPB_ENTRIES,
    parameter int TAG_WIDTH = BPB_TAG_W,
    parameter int IDX_W     = bpb_idx_w(ENTRIES),
    parameter int QDEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 res0_valid,
    input  logic [TAG_WIDTH-1:0] res0_pc,
    input  logic                 res0_taken,
    input  logic [31:0]          res0_target,
    input  logic                 res0_mistake,
    input  logic                 res1_valid,
    input  logic [TAG_WIDTH-1:0] res1_pc,
    input  logic                 res1_taken,
    input  logic [31:0]          res1_target,
    input  logic                 res1_mistake,
    output logic                 res_ready,
    output logic                 upd_valid,
    output logic                 upd_clear,
    output logic [IDX_W-1:0]     upd_idx,
    output logic [TAG_WIDTH-1:0] upd_tag,
    output logic                 upd_taken,
    output logic [31:0]          upd_target,
    output logic                 upd_mistake,
    output logic                 init_done,
    output logic [7:0]           drop_cnt
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int DW = $bits(bpb_upd_t);

    bpb_sched_state_e r_state;
    bpb_sched_state_e w_state_next;
    logic [IDX_W-1:0] r_init_ptr;
    logic [7:0]       r_drop_cnt;

    bpb_upd_t         w_res0;
    bpb_upd_t         w_res1;
    bpb_upd_t         w_data_a;
    bpb_upd_t         w_head;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_free;
    logic             w_ready;
    logic             w_push0;
    logic             w_push1;
    logic             w_push_a;
    logic             w_push_b;
    logic             w_pop;
    logic [1:0]       w_ndrop;
    logic [8:0]       w_drop_sum;

    // Pack the two resolution slots into queue entries.
    always_comb begin
        w_res0 = '{tag: res0_pc, taken: res0_taken, target: res0_target, mistake: res0_mistake};
        w_res1 = '{tag: res1_pc, taken: res1_taken, target: res1_target, mistake: res1_mistake};
    end

    // Acceptance uses the registered count, so a same-cycle pop never frees room.
    // A lone res1 is compacted onto lane a so it takes the next single slot.
    always_comb begin
        w_free   = CW'(QDEPTH) - w_count;
        w_ready  = (r_state == RUN) && (w_free >= CW'(2));
        w_push0  = w_ready && res0_valid;
        w_push1  = w_ready && res1_valid;
        w_push_a = w_push0 || w_push1;
        w_push_b = w_push0 && w_push1;
        if (w_push0) begin
            w_data_a = w_res0;
        end else begin
            w_data_a = w_res1;
        end
        w_pop = (r_state == RUN) && (w_count != '0) && !stall;
        if (w_ready) begin
            w_ndrop = 2'd0;
        end else begin
            w_ndrop = 2'(res0_valid) + 2'(res1_valid);
        end
        w_drop_sum = 9'(r_drop_cnt) + 9'(w_ndrop);
    end

    bpb_upd_fifo #(
        .DW     (DW),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_a (w_push_a),
        .data_a (w_data_a),
        .push_b (w_push_b),
        .data_b (w_res1),
        .pop    (w_pop),
        .head   (w_head),
        .count  (w_count)
    );

    // Next phase: leave the sweep after the last entry is cleared unstalled.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INIT: begin
                if (!stall && (r_init_ptr == IDX_W'(ENTRIES - 1))) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = INIT;
                end
            end
            RUN:     w_state_next = RUN;
            default: w_state_next = INIT;
        endcase
    end

    // Phase register, sweep pointer and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= INIT;
            r_init_ptr <= '0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == INIT) && !stall) begin
                r_init_ptr <= r_init_ptr + IDX_W'(1);
            end else begin
                r_init_ptr <= r_init_ptr;
            end
            if (w_drop_sum > 9'd255) begin
                r_drop_cnt <= 8'd255;
            end else begin
                r_drop_cnt <= w_drop_sum[7:0];
            end
        end
    end

    // Write-port mux: clear sweep drives zero payload, RUN drives the queue head.
    always_comb begin
        upd_valid   = 1'b1;
        upd_clear   = 1'b1;
        upd_idx     = r_init_ptr;
        upd_tag     = '0;
        upd_taken   = 1'b0;
        upd_target  = 32'd0;
        upd_mistake = 1'b0;
        init_done   = 1'b0;
        case (r_state)
            INIT: begin
                upd_valid = 1'b1;
                upd_clear = 1'b1;
                upd_idx   = r_init_ptr;
            end
            RUN: begin
                upd_valid   = (w_count != '0);
                upd_clear   = 1'b0;
                upd_idx     = w_head.tag[IDX_W-1:0];
                upd_tag     = w_head.tag;
                upd_taken   = w_head.taken;
                upd_target  = w_head.target;
                upd_mistake = w_head.mistake;
                init_done   = 1'b1;
            end
            default: begin
                upd_valid = 1'b1;
                upd_clear = 1'b1;
            end
        endcase
    end

    assign res_ready = w_ready;
    assign drop_cnt  = r_drop_cnt;

endmodule
